ps2_rx: RTL and testbench

PS2_RX -- requirements
Module: ps2_rx

---
 rtl/ps2_rx.sv | 85 ++++++++
 tb/tb_ps2_rx.sv | 120 ++++++++++++
 2 files changed

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 receive frame decoder; odd-parity checking enabled by defining PS2_RX_PARITY_CHECK_EN.
module ps2_rx #(
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic [7:0] ps2_data_o,
    output logic       ps2_data_val_o,
    output logic       frame_err_o
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
    state_t          state_q;
    logic [1:0]      clk_sync_q, dat_sync_q;
    logic            clk_last_q, par_ok_q;
    logic [2:0]      cnt_q;
    logic [7:0]      sh_q;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            fall, dat_s, timeout, par_ok;
    assign dat_s   = dat_sync_q[1];
    assign fall    = clk_last_q & ~clk_sync_q[1];
    assign timeout = state_q != IDLE && !fall && tmo_q == TW'(TIMEOUT_CYCLES);
`ifdef PS2_RX_PARITY_CHECK_EN
    assign par_ok = ^{sh_q, dat_s};
`else
    assign par_ok = 1'b1;
`endif
    always_comb begin
        tmo_d = (state_q == IDLE || fall) ? '0 : (tmo_q == TW'(TIMEOUT_CYCLES)) ? tmo_q : tmo_q + 1'b1;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            clk_sync_q     <= 2'b11;
            dat_sync_q     <= 2'b11;
            clk_last_q     <= 1'b1;
            par_ok_q       <= 1'b0;
            cnt_q          <= '0;
            sh_q           <= '0;
            tmo_q          <= '0;
            ps2_data_o     <= '0;
            ps2_data_val_o <= 1'b0;
            frame_err_o    <= 1'b0;
        end else begin
            clk_sync_q     <= {clk_sync_q[0], ps2_clk_i};
            dat_sync_q     <= {dat_sync_q[0], ps2_dat_i};
            clk_last_q     <= clk_sync_q[1];
            tmo_q          <= tmo_d;
            ps2_data_val_o <= 1'b0;
            frame_err_o    <= 1'b0;
            // a falling edge takes priority over a timeout in the same cycle
            if (timeout) begin
                state_q     <= IDLE;
                frame_err_o <= 1'b1;
            end else if (fall) begin
                case (state_q)
                    IDLE: begin
                        cnt_q <= '0;
                        if (!dat_s) state_q <= DATA;
                    end
                    DATA: begin
                        sh_q  <= {dat_s, sh_q[7:1]};
                        cnt_q <= cnt_q + 3'd1;
                        if (cnt_q == 3'd7) state_q <= PARITY;
                    end
                    PARITY: begin
                        par_ok_q <= par_ok;
                        state_q  <= STOP;
                    end
                    STOP: begin
                        state_q <= IDLE;
                        if (dat_s && par_ok_q) begin
                            ps2_data_o     <= sh_q;
                            ps2_data_val_o <= 1'b1;
                        end else begin
                            frame_err_o <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ps2_rx.sv
// tb_ps2_rx: randomized frame stimulus checked against a frame-level reference model.
module tb_ps2_rx;
    localparam int TMO = 200;
    logic clk = 0, rst = 1, ps2_clk = 1, ps2_dat = 1;
    logic [7:0] data;
    logic val, err;
    ps2_rx #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk_i(clk), .rst_i(rst), .ps2_clk_i(ps2_clk), .ps2_dat_i(ps2_dat),
        .ps2_data_o(data), .ps2_data_val_o(val), .frame_err_o(err)
    );
    always #5 clk = ~clk;
    int checks = 0, errors = 0;
    int val_cnt = 0, err_cnt = 0, both_cnt = 0, long_cnt = 0;
    int exp_val = 0, exp_err = 0, half = 10;
    logic val_prev = 0, err_prev = 0;
    logic [7:0] exp_data = 0;
    logic [7:0] got_q[$];
    always @(negedge clk) begin
        if (val) begin
            val_cnt++;
            got_q.push_back(data);
        end
        if (err) err_cnt++;
        if (val && err) both_cnt++;
        if ((val && val_prev) || (err && err_prev)) long_cnt++;
        val_prev = val;
        err_prev = err;
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic bit_out(input bit b);
        ps2_dat = b;
        repeat (half) @(negedge clk);
        ps2_clk = 0;
        repeat (half) @(negedge clk);
        ps2_clk = 1;
    endtask
    task automatic partial(input logic [7:0] b, input int n);
        bit_out(0);
        for (int i = 0; i < n; i++) bit_out(b[i]);
        ps2_dat = 1;
    endtask
    task automatic frame(input logic [7:0] b, input bit par, input bit stp);
        bit good;
        partial(b, 8);
        bit_out(par);
        bit_out(stp);
        ps2_dat = 1;
`ifdef PS2_RX_PARITY_CHECK_EN
        good = stp && (($countones(b) + int'(par)) % 2 == 1);
`else
        good = stp;
`endif
        if (good) begin
            exp_val++;
            exp_data = b;
        end else exp_err++;
    endtask
    task automatic check_state(input string tag);
        check({tag, ".val_cnt"}, val_cnt, exp_val);
        check({tag, ".err_cnt"}, err_cnt, exp_err);
        check({tag, ".data"}, data, exp_data);
    endtask
    initial begin
        int n;
        logic [7:0] b;
        repeat (3) @(negedge clk);
        check("rst.data", data, 8'h00);
        check("rst.val", val, 0);
        check("rst.err", err, 0);
        rst = 0;
        repeat (5) @(negedge clk);
        frame(8'h1C, 0, 1);
        check_state("f1c");
        n = got_q.size();
        frame(8'hF0, 1, 1);
        frame(8'h16, 0, 1);
        check_state("b2b");
        check("b2b.n", got_q.size(), n + 2);
        if (got_q.size() >= 2) begin
            check("b2b.first", got_q[got_q.size()-2], 8'hF0);
            check("b2b.second", got_q[got_q.size()-1], 8'h16);
        end
        frame(8'h3E, 1, 1);
        check_state("badpar");
        frame(8'h26, 0, 0);
        check_state("badstop");
        partial(8'hA5, 4);
        repeat (TMO + 10) @(negedge clk);
        exp_err++;
        check_state("timeout");
        frame(8'h45, 0, 1);
        check_state("f45");
        partial(8'h77, 5);
        rst = 1;
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        exp_data = 0;
        check_state("midrst");
        check("midrst.val", val, 0);
        frame(8'h16, 0, 1);
        check_state("after_rst");
        for (int i = 0; i < 24; i++) begin
            half = $urandom_range(8, 30);
            b = 8'($urandom);
            frame(b, (~^b) ^ ($urandom_range(0, 3) == 0), $urandom_range(0, 4) != 0);
            check_state("rand");
        end
        check("excl", both_cnt, 0);
        check("one_cycle", long_cnt, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
